// File: rtl/ddr3_app_ctrl_if.sv
// User request/response stream plus DDR3 controller app/wdf/rd channels.
// Modports: master = the app controller block, slave = its environment.
interface ddr3_app_ctrl_if #(
  parameter int ADDR_W = 28
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [511:0]      req_data;
  logic [63:0]       req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [511:0]      rsp_data;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic [511:0]      app_wdf_data;
  logic [63:0]       app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [511:0]      app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              init_calib_complete;
  logic              err_unexp_rd;

  modport master (
    input  req_valid, req_write, req_addr, req_data, req_mask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end, init_calib_complete,
    output req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, err_unexp_rd
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, req_mask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end, init_calib_complete,
    input  req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, err_unexp_rd
  );
endinterface

// File: rtl/ddr3_app_ctrl.sv
// Single-request DDR3 app-interface sequencer: 1-cycle accept-to-issue, app_en/wdf_wren held until handshake.
// Reads are credit-limited to MAX_RD; read beats land in a MAX_RD-deep FWFT FIFO drained by rsp_ready.
module ddr3_app_ctrl #(
  parameter int MAX_RD = 16,
  parameter int ADDR_W = 28
) (
  input logic             CLK,
  input logic             RST_N,
  ddr3_app_ctrl_if.master bus
);
  localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_RD);

  typedef enum logic [1:0] {INIT, IDLE, WR, RD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [511:0]      r_wdata;
  logic [63:0]       r_mask;
  logic              r_app_en;
  logic              r_wdf_wren;
  logic [2:0]        r_app_cmd;
  logic [CNT_W-1:0]  r_credits;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              r_err;
  logic [511:0]      r_mem [MAX_RD];

  logic w_req_ready, w_accept, w_cmd_hs, w_wdf_hs, w_cmd_done, w_wdf_done;
  logic w_rd_issue, w_pop, w_push, w_unexp, w_calib;

  assign w_calib     = bus.init_calib_complete;
  assign w_req_ready = (r_state == IDLE) && w_calib && (bus.req_write || (r_credits != '0));
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_cmd_hs    = r_app_en && bus.app_rdy;
  assign w_wdf_hs    = r_wdf_wren && bus.app_wdf_rdy;
  // "done" covers both an earlier handshake and one completing this cycle
  assign w_cmd_done  = !r_app_en || bus.app_rdy;
  assign w_wdf_done  = !r_wdf_wren || bus.app_wdf_rdy;
  assign w_rd_issue  = (r_state == RD) && w_cmd_hs;
  assign w_pop       = (r_count != '0) && bus.rsp_ready;
  assign w_unexp     = bus.app_rd_data_valid && (r_credits == FULL_CNT);
  assign w_push      = bus.app_rd_data_valid && !w_unexp && (r_count != FULL_CNT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= INIT;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_app_en   <= 1'b0;
      r_wdf_wren <= 1'b0;
      r_app_cmd  <= 3'b000;
    end else begin
      case (r_state)
        INIT: if (w_calib) r_state <= IDLE;
        IDLE: begin
          if (!w_calib) begin
            r_state <= INIT;
          end else if (w_accept) begin
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_data;
            r_mask     <= bus.req_mask;
            r_app_en   <= 1'b1;
            r_wdf_wren <= bus.req_write;
            r_app_cmd  <= bus.req_write ? 3'b000 : 3'b001;
            r_state    <= bus.req_write ? WR : RD;
          end
        end
        WR: begin
          if (w_cmd_hs) r_app_en <= 1'b0;
          if (w_wdf_hs) r_wdf_wren <= 1'b0;
          if (w_cmd_done && w_wdf_done) r_state <= w_calib ? IDLE : INIT;
        end
        RD: begin
          if (w_cmd_hs) begin
            r_app_en  <= 1'b0;
            r_app_cmd <= 3'b000;
            r_state   <= w_calib ? IDLE : INIT;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // Credits return on response pop, so a credit covers a read until the user consumes its data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_credits <= FULL_CNT;
    end else begin
      case ({w_rd_issue, w_pop})
        2'b10:   if (r_credits != '0) r_credits <= r_credits - CNT_W'(1);
        2'b01:   if (r_credits != FULL_CNT) r_credits <= r_credits + CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_unexp) r_err <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.app_rd_data;
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.rsp_valid    = (r_count != '0);
  assign bus.rsp_data     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.app_addr     = r_addr;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_en       = r_app_en;
  assign bus.app_wdf_data = r_wdata;
  assign bus.app_wdf_mask = r_mask;
  assign bus.app_wdf_wren = r_wdf_wren;
  assign bus.app_wdf_end  = r_wdf_wren;
  assign bus.err_unexp_rd = r_err;
endmodule

// File: tb/tb_ddr3_app_ctrl.sv
// Scoreboard bench: accepted requests and driven read beats queue expectations; a negedge monitor checks them.
module tb_ddr3_app_ctrl;
  localparam int AW   = 28;
  localparam int MAXR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ddr3_app_ctrl_if #(.ADDR_W(AW)) bus ();
  ddr3_app_ctrl #(.MAX_RD(MAXR), .ADDR_W(AW)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  int n_chk = 0;
  int n_bad = 0;
  logic [AW+2:0]  cmd_q [$];
  logic [575:0]   wd_q  [$];
  logic [511:0]   rsp_q [$];

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) begin
        cmd_q.push_back({(bus.req_write ? 3'b000 : 3'b001), bus.req_addr});
        if (bus.req_write) wd_q.push_back({bus.req_data, bus.req_mask});
      end
      if (bus.app_en && bus.app_rdy) begin
        if (cmd_q.size() == 0) chk("cmd_extra", 1, 0);
        else chk("cmd", {bus.app_cmd, bus.app_addr}, cmd_q.pop_front());
      end
      if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
        chk("wdf_end", bus.app_wdf_end, 1);
        if (wd_q.size() == 0) chk("wdf_extra", 1, 0);
        else chk("wdf", {bus.app_wdf_data, bus.app_wdf_mask}, wd_q.pop_front());
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_extra", 1, 0);
        else chk("rsp_data", bus.rsp_data, rsp_q.pop_front());
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [511:0] d, input logic [63:0] m);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = d; bus.req_mask = m;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic beat(input logic [511:0] d, input bit kept);
    @(posedge clk); #1;
    bus.app_rd_data_valid = 1'b1; bus.app_rd_data = d; bus.app_rd_data_end = 1'b1;
    if (kept) rsp_q.push_back(d);
    @(posedge clk); #1;
    bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 30 && !idle; n++) begin
      @(negedge clk);
      idle = !bus.app_en && !bus.app_wdf_wren;
    end
    chk("idle_wait", idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_data = '0; bus.req_mask = '0;
    bus.rsp_ready = 0; bus.app_rdy = 1; bus.app_wdf_rdy = 1; bus.app_rd_data = '0;
    bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0; bus.init_calib_complete = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_app_en", bus.app_en, 0);
    chk("rst_wren", {bus.app_wdf_wren, bus.app_wdf_end}, 0);
    chk("rst_cmd_addr", {bus.app_cmd, bus.app_addr}, 0);
    chk("rst_wdata", {bus.app_wdf_data, bus.app_wdf_mask}, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_err", bus.err_unexp_rd, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // calibration gate
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 28'h0001234;
    bus.req_data = {16{32'hDEADBEEF}}; bus.req_mask = 64'h0F;
    repeat (3) begin
      @(negedge clk);
      chk("gate_rdy", bus.req_ready, 0);
      chk("gate_en", bus.app_en, 0);
    end
    @(posedge clk); #1 bus.init_calib_complete = 1;
    @(negedge clk); chk("gate_still_init", bus.req_ready, 0);
    @(negedge clk); chk("gate_rdy_up", bus.req_ready, 1);
    @(posedge clk); #1 bus.req_valid = 0;
    @(negedge clk);
    chk("gate_en_lat1", bus.app_en, 1);
    chk("gate_wren_lat1", bus.app_wdf_wren, 1);
    wait_idle();

    // write with command stalled, data accepted first
    bus.app_rdy = 0;
    send(1, 28'h0ABCDE0, {16{32'h12345678}}, 64'hF0F0_0000_0000_F0F0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_en_hold", bus.app_en, 1);
      chk("w_addr_hold", {bus.app_cmd, bus.app_addr}, {3'b000, 28'h0ABCDE0});
      chk("w_wren", bus.app_wdf_wren, (i == 0));
      chk("w_no_accept", bus.req_ready, 0);
    end
    @(posedge clk); #1 bus.app_rdy = 1;
    @(negedge clk); chk("w_en_last", bus.app_en, 1);
    @(negedge clk);
    chk("w_done_en", bus.app_en, 0);
    chk("w_idle_rdy", bus.req_ready, 1);

    // exhaust read credits
    for (int i = 0; i < MAXR; i++) send(0, AW'(28'h100 + i), '0, '0);
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 28'h200;
    repeat (4) begin
      @(negedge clk);
      chk("rd_no_credit", bus.req_ready, 0);
    end
    @(posedge clk); #1 bus.req_valid = 0;
    send(1, 28'h300, {16{32'hCAFEF00D}}, 64'h0);
    wait_idle();
    fork
      send(0, 28'h200, '0, '0);
      begin
        beat({16{32'hAAAAAAAA}}, 1);
        @(posedge clk); #1 bus.rsp_ready = 1;
        @(posedge clk); #1 bus.rsp_ready = 0;
      end
    join

    // remaining beats with toggling rsp_ready
    for (int k = 0; k < MAXR; k++) begin
      bus.rsp_ready = k[0];
      beat({16{32'(k * 32'h01010101 + 32'hBBBBBBBB)}}, 1);
    end
    for (int n = 0; n < 200 && rsp_q.size() != 0; n++) begin
      @(posedge clk); #1 bus.rsp_ready = ~bus.rsp_ready;
    end
    chk("drain_left", rsp_q.size(), 0);
    @(posedge clk); #1 bus.rsp_ready = 0;
    @(negedge clk);
    chk("drain_empty", bus.rsp_valid, 0);
    chk("err_clean", bus.err_unexp_rd, 0);
    // credits back at full: a stray beat must flag an error
    beat({16{32'h55555555}}, 0);
    @(negedge clk);
    chk("stray_err", bus.err_unexp_rd, 1);
    chk("stray_dropped", bus.rsp_valid, 0);

    // calibration loss from IDLE
    @(posedge clk); #1 bus.init_calib_complete = 0;
    @(negedge clk); chk("calib_drop_rdy", bus.req_ready, 0);
    @(posedge clk); #1 bus.init_calib_complete = 1;
    repeat (2) @(negedge clk);

    // reset during a stalled write
    bus.app_rdy = 0;
    send(1, 28'h7777, {16{32'h0BADCAFE}}, 64'h1);
    @(negedge clk); chk("pre_rst_en", bus.app_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", bus.app_en, 0);
    chk("rst_mid_err", bus.err_unexp_rd, 0);
    chk("rst_mid_cmd", {bus.app_cmd, bus.app_addr}, 0);
    cmd_q.delete();
    wd_q.delete();
    @(posedge clk); #1 rst_n = 1'b1; bus.app_rdy = 1;
    @(negedge clk); chk("post_rst_init", bus.req_ready, 0);
    @(negedge clk); chk("post_rst_idle", bus.req_ready, 1);

    // read data with nothing outstanding
    beat({16{32'h0F0F0F0F}}, 0);
    repeat (3) @(negedge clk);
    chk("unexp_err", bus.err_unexp_rd, 1);
    chk("unexp_empty", bus.rsp_valid, 0);
    #2 rst_n = 1'b0;
    #1 chk("unexp_err_clr", bus.err_unexp_rd, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    chk("queues_empty", cmd_q.size() + wd_q.size() + rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
